// File: rtl/ex_issue_stage_if.sv
// ID/EX issue-stage bus: ID-side instruction fields, forwarding sources and EX-side handshake/operands.
// The master drives the ID fields, the forwarding sources and ex_ready; the slave is the issue stage.
interface ex_issue_stage_if #(
  parameter int unsigned W    = 32,
  parameter int unsigned RIDX = 5
);
  logic            id_valid;
  logic            id_ready;
  logic            flush;
  logic [1:0]      id_alu_op;
  logic [5:0]      id_funct;
  logic [W-1:0]    id_rs_data;
  logic [W-1:0]    id_rt_data;
  logic [W-1:0]    id_imm;
  logic            id_alu_src;
  logic [RIDX-1:0] id_rs;
  logic [RIDX-1:0] id_rt;
  logic [RIDX-1:0] id_rd;
  logic            id_reg_write;

  logic            exmem_reg_write;
  logic [RIDX-1:0] exmem_rd;
  logic [W-1:0]    exmem_result;
  logic            memwb_reg_write;
  logic [RIDX-1:0] memwb_rd;
  logic [W-1:0]    memwb_result;

  logic            ex_ready;
  logic            ex_valid;
  logic [3:0]      alu_ctl;
  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic [W-1:0]    ex_store_data;
  logic [RIDX-1:0] ex_rd;
  logic            ex_reg_write;
  logic            ex_illegal;

  modport master (
    output id_valid, flush, id_alu_op, id_funct, id_rs_data, id_rt_data, id_imm,
           id_alu_src, id_rs, id_rt, id_rd, id_reg_write,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result, ex_ready,
    input  id_ready, ex_valid, alu_ctl, alu_a, alu_b, ex_store_data,
           ex_rd, ex_reg_write, ex_illegal
  );

  modport slave (
    input  id_valid, flush, id_alu_op, id_funct, id_rs_data, id_rt_data, id_imm,
           id_alu_src, id_rs, id_rt, id_rd, id_reg_write,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result, ex_ready,
    output id_ready, ex_valid, alu_ctl, alu_a, alu_b, ex_store_data,
           ex_rd, ex_reg_write, ex_illegal
  );
endinterface

// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register and issue stage: ALU control decode, RAW forwarding from EX/MEM and MEM/WB,
// and a valid/ready handshake toward EX.
module ex_issue_stage #(
  parameter int unsigned W    = 32,
  parameter int unsigned RIDX = 5
) (
  input  logic             clk,
  input  logic             reset,
  ex_issue_stage_if.slave  bus
);

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  logic            valid_q;
  logic [3:0]      alu_ctl_q;
  logic [RIDX-1:0] rd_q;
  logic            reg_write_q;
  logic            illegal_q;
  logic [RIDX-1:0] rs_q;
  logic [RIDX-1:0] rt_q;
  logic [W-1:0]    rs_data_q;
  logic [W-1:0]    rt_data_q;
  logic [W-1:0]    imm_q;
  logic            alu_src_q;

  logic            ready_c;
  logic            load_c;
  logic [3:0]      dec_ctl_c;
  logic            dec_illegal_c;
  logic [W-1:0]    rs_fwd_c;
  logic [W-1:0]    rt_fwd_c;

  assign ready_c = ~valid_q | bus.ex_ready;
  assign load_c  = bus.id_valid & ready_c;

  // ALUOp/funct to ALU control word; unsupported funct falls back to add and is flagged
  always_comb begin
    dec_ctl_c     = CTL_ADD;
    dec_illegal_c = 1'b0;
    unique case (bus.id_alu_op)
      2'b00: dec_ctl_c = CTL_ADD;
      2'b01: dec_ctl_c = CTL_SUB;
      2'b11: dec_ctl_c = CTL_OR;
      default: begin
        case (bus.id_funct)
          6'b100000: dec_ctl_c = CTL_ADD;
          6'b100010: dec_ctl_c = CTL_SUB;
          6'b100100: dec_ctl_c = CTL_AND;
          6'b100101: dec_ctl_c = CTL_OR;
          6'b101010: dec_ctl_c = CTL_SLT;
          6'b100111: dec_ctl_c = CTL_NOR;
          default:   dec_illegal_c = 1'b1;
        endcase
      end
    endcase
  end

  // Pipeline register: reset > flush > load > drain; otherwise hold (covers stall)
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      alu_ctl_q   <= 4'b0000;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
    end else if (bus.flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (load_c) begin
      valid_q     <= 1'b1;
      alu_ctl_q   <= dec_ctl_c;
      rd_q        <= bus.id_rd;
      reg_write_q <= bus.id_reg_write & ~dec_illegal_c;
      illegal_q   <= dec_illegal_c;
      rs_q        <= bus.id_rs;
      rt_q        <= bus.id_rt;
      rs_data_q   <= bus.id_rs_data;
      rt_data_q   <= bus.id_rt_data;
      imm_q       <= bus.id_imm;
      alu_src_q   <= bus.id_alu_src;
    end else if (valid_q & bus.ex_ready) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end
  end

  // Forwarding stays live during a stall so held operands pick up newly retiring producers
  always_comb begin
    rs_fwd_c = rs_data_q;
    if (bus.exmem_reg_write && (bus.exmem_rd == rs_q) && (rs_q != '0))
      rs_fwd_c = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd == rs_q) && (rs_q != '0))
      rs_fwd_c = bus.memwb_result;
  end

  always_comb begin
    rt_fwd_c = rt_data_q;
    if (bus.exmem_reg_write && (bus.exmem_rd == rt_q) && (rt_q != '0))
      rt_fwd_c = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd == rt_q) && (rt_q != '0))
      rt_fwd_c = bus.memwb_result;
  end

  assign bus.id_ready      = ready_c;
  assign bus.ex_valid      = valid_q;
  assign bus.alu_ctl       = alu_ctl_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_reg_write  = reg_write_q & valid_q;
  assign bus.ex_illegal    = illegal_q;
  assign bus.alu_a         = rs_fwd_c;
  assign bus.alu_b         = alu_src_q ? imm_q : rt_fwd_c;
  assign bus.ex_store_data = rt_fwd_c;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed bench for ex_issue_stage: reset, decode, forwarding, stall, flush and illegal-funct cases.
module tb_ex_issue_stage;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ex_issue_stage_if #(.W(32), .RIDX(5)) bus ();

  ex_issue_stage #(.W(32), .RIDX(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic valid, input logic [1:0] op, input logic [5:0] funct,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rs_data, input logic [31:0] rt_data,
                          input logic [31:0] imm, input logic src, input logic we);
    bus.id_valid     = valid;
    bus.id_alu_op    = op;
    bus.id_funct     = funct;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = rd;
    bus.id_rs_data   = rs_data;
    bus.id_rt_data   = rt_data;
    bus.id_imm       = imm;
    bus.id_alu_src   = src;
    bus.id_reg_write = we;
  endtask

  task automatic clear_fwd();
    bus.exmem_reg_write = 1'b0;
    bus.exmem_rd        = '0;
    bus.exmem_result    = '0;
    bus.memwb_reg_write = 1'b0;
    bus.memwb_rd        = '0;
    bus.memwb_result    = '0;
  endtask

  logic [5:0] fn_tab  [4] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};
  logic [3:0] ctl_tab [4] = '{4'b0010,   4'b0110,   4'b0000,   4'b0001};

  initial begin
    reset    = 1'b1;
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;
    clear_fwd();
    drive_id(1'b1, 2'b01, 6'd0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 1'b0, 1'b1);
    step();
    step();
    check("rst_valid", 32'(bus.ex_valid), 32'd0);
    check("rst_ctl", 32'(bus.alu_ctl), 32'd0);
    check("rst_we", 32'(bus.ex_reg_write), 32'd0);
    check("rst_ready", 32'(bus.id_ready), 32'd1);

    // R-type slt, no hazard
    reset = 1'b0;
    drive_id(1'b1, 2'b10, 6'b101010, 5'd3, 5'd4, 5'd7, 32'h1234, 32'h5678, 32'h0, 1'b0, 1'b1);
    step();
    check("slt_valid", 32'(bus.ex_valid), 32'd1);
    check("slt_ctl", 32'(bus.alu_ctl), 32'h7);
    check("slt_a", bus.alu_a, 32'h1234);
    check("slt_b", bus.alu_b, 32'h5678);
    check("slt_store", bus.ex_store_data, 32'h5678);
    check("slt_rd", 32'(bus.ex_rd), 32'd7);
    check("slt_we", 32'(bus.ex_reg_write), 32'd1);
    check("slt_ill", 32'(bus.ex_illegal), 32'd0);

    // Back-to-back R-type decodes
    for (int i = 0; i < 4; i++) begin
      drive_id(1'b1, 2'b10, fn_tab[i], 5'd1, 5'd2, 5'd3, 32'h10, 32'h20, 32'h0, 1'b0, 1'b1);
      step();
      check($sformatf("rtype_ctl%0d", i), 32'(bus.alu_ctl), 32'(ctl_tab[i]));
    end

    // Drain
    bus.id_valid = 1'b0;
    step();
    check("drain_valid", 32'(bus.ex_valid), 32'd0);
    check("drain_we", 32'(bus.ex_reg_write), 32'd0);

    // Forwarding on a held instruction: rs=5, rt=6
    drive_id(1'b1, 2'b00, 6'd0, 5'd5, 5'd6, 5'd8, 32'hAAAA, 32'hBBBB, 32'h0, 1'b0, 1'b1);
    step();
    bus.id_valid = 1'b0;
    bus.ex_ready = 1'b0;
    check("add_ctl", 32'(bus.alu_ctl), 32'h2);
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_result = 32'h11;
    bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd5; bus.memwb_result = 32'h22;
    #1;
    check("fwd_exmem_pri", bus.alu_a, 32'h11);
    check("fwd_rt_none", bus.alu_b, 32'hBBBB);
    bus.exmem_reg_write = 1'b0;
    #1;
    check("fwd_memwb", bus.alu_a, 32'h22);
    bus.memwb_rd = 5'd6;
    #1;
    check("fwd_rs_reg", bus.alu_a, 32'hAAAA);
    check("fwd_rt_memwb", bus.alu_b, 32'h22);
    check("fwd_store", bus.ex_store_data, 32'h22);
    step();
    check("fwd_stall_valid", 32'(bus.ex_valid), 32'd1);
    check("fwd_stall_a", bus.alu_a, 32'hAAAA);

    // Register 0 never forwarded
    clear_fwd();
    bus.ex_ready = 1'b1;
    drive_id(1'b1, 2'b01, 6'd0, 5'd0, 5'd0, 5'd3, 32'h5, 32'h9, 32'h0, 1'b0, 1'b1);
    step();
    bus.id_valid = 1'b0;
    bus.ex_ready = 1'b0;
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'h11;
    bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'h22;
    #1;
    check("r0_a", bus.alu_a, 32'h5);
    check("r0_b", bus.alu_b, 32'h9);
    check("sub_ctl", 32'(bus.alu_ctl), 32'h6);
    clear_fwd();

    // Stall with a pending instruction for 3 cycles
    drive_id(1'b1, 2'b11, 6'd0, 5'd1, 5'd2, 5'd9, 32'h100, 32'h200, 32'h0, 1'b0, 1'b1);
    #1;
    check("stall_ready", 32'(bus.id_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_valid%0d", i), 32'(bus.ex_valid), 32'd1);
      check($sformatf("stall_ctl%0d", i), 32'(bus.alu_ctl), 32'h6);
      check($sformatf("stall_rd%0d", i), 32'(bus.ex_rd), 32'd3);
      check($sformatf("stall_a%0d", i), bus.alu_a, 32'h5);
    end
    bus.ex_ready = 1'b1;
    #1;
    check("unstall_ready", 32'(bus.id_ready), 32'd1);
    step();
    check("unstall_ctl", 32'(bus.alu_ctl), 32'h1);
    check("unstall_a", bus.alu_a, 32'h100);
    check("unstall_rd", 32'(bus.ex_rd), 32'd9);

    // Flush concurrent with a new instruction
    drive_id(1'b1, 2'b01, 6'd0, 5'd4, 5'd4, 5'd12, 32'h7, 32'h7, 32'h0, 1'b0, 1'b1);
    bus.flush = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.id_valid = 1'b0;
    check("flush_valid", 32'(bus.ex_valid), 32'd0);
    check("flush_we", 32'(bus.ex_reg_write), 32'd0);
    check("flush_rd_kept", 32'(bus.ex_rd), 32'd9);
    step();
    check("flush_dropped", 32'(bus.ex_valid), 32'd0);

    // Flush during a stall
    drive_id(1'b1, 2'b00, 6'd0, 5'd1, 5'd1, 5'd2, 32'h1, 32'h1, 32'h0, 1'b0, 1'b1);
    step();
    bus.id_valid = 1'b0;
    bus.ex_ready = 1'b0;
    bus.flush    = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_stall_valid", 32'(bus.ex_valid), 32'd0);
    check("flush_stall_ready", 32'(bus.id_ready), 32'd1);
    bus.ex_ready = 1'b1;

    // Illegal funct
    drive_id(1'b1, 2'b10, 6'b000000, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1);
    step();
    check("ill_valid", 32'(bus.ex_valid), 32'd1);
    check("ill_flag", 32'(bus.ex_illegal), 32'd1);
    check("ill_ctl", 32'(bus.alu_ctl), 32'h2);
    check("ill_we", 32'(bus.ex_reg_write), 32'd0);

    // NOR with immediate operand B
    drive_id(1'b1, 2'b10, 6'b100111, 5'd1, 5'd2, 5'd3, 32'hF0, 32'h3, 32'hFFFF0000, 1'b1, 1'b1);
    step();
    check("nor_ctl", 32'(bus.alu_ctl), 32'hC);
    check("nor_b", bus.alu_b, 32'hFFFF0000);
    check("nor_store", bus.ex_store_data, 32'h3);
    check("nor_ill", 32'(bus.ex_illegal), 32'd0);
    check("nor_we", 32'(bus.ex_reg_write), 32'd1);

    // Reset beats flush and load
    reset     = 1'b1;
    bus.flush = 1'b1;
    step();
    check("rstpri_valid", 32'(bus.ex_valid), 32'd0);
    check("rstpri_ctl", 32'(bus.alu_ctl), 32'd0);
    check("rstpri_b", bus.alu_b, 32'd0);
    reset     = 1'b0;
    bus.flush = 1'b0;
    bus.id_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
- ID/EX pipeline register and issue stage for the pipelined CLA datapath.
- Registers decoded instruction fields and translates ALUOp/funct into the 4-bit ALU control word consumed by the 32-bit ALU.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, then presents final ALU operands with a valid/ready handshake to the EX stage.

Parameters:
- W, 32, datapath width
- RIDX, 5, register index width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID presents an instruction
- id_ready  out  1  stage can accept; equals ~ex_valid | ex_ready
- flush  in  1  kill the registered instruction (branch mispredict)
- id_alu_op  in  2  00 add, 01 sub, 10 R-type funct, 11 or
- id_funct  in  6  R-type function field
- id_rs_data, id_rt_data  in  W  register file read data
- id_imm  in  W  extended immediate
- id_alu_src  in  1  1 selects immediate for operand B
- id_rs, id_rt, id_rd  in  RIDX  source and destination indices
- id_reg_write  in  1  instruction writes rd
- exmem_reg_write  in  1  EX/MEM forwarding source write enable
- exmem_rd  in  RIDX  EX/MEM forwarding source destination
- exmem_result  in  W  EX/MEM forwarding source result
- memwb_reg_write  in  1  MEM/WB forwarding source write enable
- memwb_rd  in  RIDX  MEM/WB forwarding source destination
- memwb_result  in  W  MEM/WB forwarding source result
- ex_ready  in  1  EX consumes the current instruction
- ex_valid  out  1  registered instruction valid
- alu_ctl  out  4  registered ALU control: [3] invert A, [2] invert B and carry-in, [1:0] 00 and, 01 or, 10 add, 11 slt
- alu_a, alu_b  out  W  forwarded operands (combinational from registered state)
- ex_store_data  out  W  forwarded rt value
- ex_rd  out  RIDX  registered destination
- ex_reg_write  out  1  registered write enable, forced 0 when ex_valid=0
- ex_illegal  out  1  registered: unsupported funct decoded

Behaviour:
- Reset:
  - All registers cleared: ex_valid=0, alu_ctl=0000, ex_rd=0, ex_reg_write=0, ex_illegal=0, data registers=0.
  - Reset has priority over flush and load.
- Load: when id_valid & id_ready, all id_* fields are registered and ex_valid=1 next cycle. Latency is 1 cycle.
- Drain: when ex_valid & ex_ready & ~(id_valid & id_ready), ex_valid=0 next cycle.
- Stall: when ex_valid & ~ex_ready, all registers hold, id_ready=0, and outputs are stable.
- Flush: sets ex_valid=0 and ex_reg_write=0 next cycle.
  - Flush has priority over load; a simultaneous id_valid is dropped.
  - Flush during a stall also clears the stage.
- Decode, registered at load:
  - alu_op 00 -> 0010
  - alu_op 01 -> 0110
  - alu_op 11 -> 0001
  - alu_op 10 with funct 100000 -> 0010 (add)
  - alu_op 10 with funct 100010 -> 0110 (sub)
  - alu_op 10 with funct 100100 -> 0000 (and)
  - alu_op 10 with funct 100101 -> 0001 (or)
  - alu_op 10 with funct 101010 -> 0111 (slt)
  - alu_op 10 with funct 100111 -> 1100 (nor)
  - Any other funct -> alu_ctl=0010, ex_illegal=1, ex_reg_write=0.
- Forwarding, combinational, evaluated every cycle including during a stall so that operands track newly retiring producers:
  - Source rs forwards from EX/MEM if exmem_reg_write & exmem_rd==rs & rs!=0.
  - Otherwise rs forwards from MEM/WB if memwb_reg_write & memwb_rd==rs & rs!=0.
  - Otherwise rs uses the registered data. Same rules apply to rt.
  - EX/MEM has priority when both sources match.
  - Register 0 is never forwarded.
- Operand select:
  - alu_a = forwarded rs.
  - alu_b = alu_src ? registered imm : forwarded rt.
  - ex_store_data = forwarded rt, always.

Test Plan:
- Reset asserted with id_valid=1 -> ex_valid=0, alu_ctl=0000, ex_reg_write=0 on the next cycle.
- Load R-type funct=101010, rs=3, rt=4, no hazard -> after 1 cycle alu_ctl=0111, alu_a=id_rs_data, alu_b=id_rt_data, ex_valid=1.
- Registered rs=5; exmem_rd=5 with exmem_result=0x11; memwb_rd=5 with memwb_result=0x22 -> alu_a=0x11. Drop exmem_reg_write -> alu_a=0x22. Repeat with rs=0 -> no forwarding.
- ex_ready=0 for 3 cycles with id_valid=1 -> id_ready=0 and outputs hold. Then ex_ready=1 -> the next instruction loads 1 cycle later.
- flush=1 concurrent with id_valid=1 -> ex_valid=0 and ex_reg_write=0 next cycle; the new instruction is not captured.
- alu_op=10, funct=000000 -> ex_illegal=1, alu_ctl=0010, ex_reg_write=0. alu_op=10, funct=100111, alu_src=1 -> alu_ctl=1100, alu_b=id_imm.
